// File: rtl/axil_iic_initiator.sv
// rtl/axil_iic_initiator.sv - single-entry command/response to AXI4-Lite initiator for the IIC controller
// Optional watchdog built when AXIL_IIC_INIT_TIMEOUT_EN is defined.
module axil_iic_initiator #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              aresetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

`ifdef AXIL_IIC_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;

  assign busy  = (state_q == WR) || (state_q == WRESP) ||
                 (state_q == RADDR) || (state_q == RDATA);
  // Entry to WR/RADDR is always from IDLE, where the count is held at zero.
  assign cnt_d = busy ? cnt_q + 1'b1 : '0;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = 1'b0;
    arvalid_d   = arvalid_q;
    rready_d    = 1'b0;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          awaddr_d    = cmd_addr;
          araddr_d    = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        // A channel already low has completed its handshake earlier.
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        bready_d = 1'b1;
        if (bready_q && m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = RSP;
        end
      end
      RADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        rready_d = 1'b1;
        if (rready_q && m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_IIC_INIT_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
    if (state_q != RSP && state_d == RSP) rsp_timeout_d = 1'b0;
    // Bus treated as dead: abandon the handshake even though valids were high.
    if (busy && cnt_q == CNT_LAST) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      state_d       = RSP;
    end
`endif
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXIL_IIC_INIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_iic_initiator.sv
// tb/tb_axil_iic_initiator.sv - directed self-checking bench for axil_iic_initiator
// Watchdog scenario runs only when AXIL_IIC_INIT_TIMEOUT_EN is defined.
module tb_axil_iic_initiator;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]       m_axi_wdata, m_axi_rdata;
  logic [3:0]        m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;

  int checks   = 0;
  int failures = 0;

  axil_iic_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
    m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = 32'h0;
  endtask

  task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0;
  endtask

  // Zero-wait slave: every ready and the response valid held high from the start.
  task automatic run_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [1:0] sresp, input logic [31:0] srdata, output int lat);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bvalid = w; m_axi_rvalid = !w;
    m_axi_bresp = sresp; m_axi_rresp = sresp; m_axi_rdata = srdata;
    send_cmd(w, a, d, 4'hF);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    clear_slave();
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    clear_slave();
    #12;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready act=%0b exp=1", cmd_ready); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      failures++; $display("FAIL rst_axi_hs act=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== 36'h0) begin
      failures++; $display("FAIL rst_rsp act=%0h exp=0", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}); end
    checks++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== '0) begin
      failures++; $display("FAIL rst_addr_data act=%0h exp=0", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}); end
    @(posedge clk); #1;
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wz_cmd_ready_pre act=%0b exp=1", cmd_ready); end
    send_cmd(1'b1, 9'h100, 32'h0000_00A5, 4'hF);
    // cycle T+1
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin failures++; $display("FAIL wz_valids act=%b exp=11", {m_axi_awvalid, m_axi_wvalid}); end
    checks++; if (m_axi_awaddr !== 9'h100) begin failures++; $display("FAIL wz_awaddr act=%0h exp=100", m_axi_awaddr); end
    checks++; if (m_axi_wdata !== 32'hA5) begin failures++; $display("FAIL wz_wdata act=%0h exp=a5", m_axi_wdata); end
    checks++; if (m_axi_wstrb !== 4'hF) begin failures++; $display("FAIL wz_wstrb act=%0h exp=f", m_axi_wstrb); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wz_cmd_ready_busy act=%0b exp=0", cmd_ready); end
    tick();
    // cycle T+2: both handshakes done, slave raises bvalid
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    checks++; if ({m_axi_awvalid, m_axi_wvalid, rsp_valid} !== 3'b000) begin
      failures++; $display("FAIL wz_t2 act=%b exp=000", {m_axi_awvalid, m_axi_wvalid, rsp_valid}); end
    tick();
    checks++; if ({m_axi_bready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL wz_t3 act=%b exp=10", {m_axi_bready, rsp_valid}); end
    tick();
    m_axi_bvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wz_rsp_t4 act=%0b exp=1", rsp_valid); end
    checks++; if ({rsp_resp, rsp_rdata, rsp_timeout, m_axi_bready} !== 36'h0) begin
      failures++; $display("FAIL wz_rsp_fields act=%0h exp=0", {rsp_resp, rsp_rdata, rsp_timeout, m_axi_bready}); end
    finish_rsp();
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL wz_idle act=%b exp=10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_read_delayed_ar();
    clear_slave();
    send_cmd(1'b0, 9'h104, 32'h0, 4'h0);
    checks++; if (m_axi_araddr !== 9'h104) begin failures++; $display("FAIL rd_araddr act=%0h exp=104", m_axi_araddr); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_axi_arready = 1'b1;
      checks++; if (m_axi_arvalid !== 1'b1) begin failures++; $display("FAIL rd_arvalid_hold%0d act=%0b exp=1", i, m_axi_arvalid); end
      tick();
    end
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
    checks++; if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin failures++; $display("FAIL rd_after_ar act=%b exp=00", {m_axi_arvalid, m_axi_rready}); end
    tick();
    checks++; if (m_axi_rready !== 1'b1) begin failures++; $display("FAIL rd_rready act=%0b exp=1", m_axi_rready); end
    tick();
    clear_slave();
    checks++; if ({rsp_valid, m_axi_rready} !== 2'b10) begin failures++; $display("FAIL rd_rsp_valid act=%b exp=10", {rsp_valid, m_axi_rready}); end
    checks++; if (rsp_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_rdata act=%0h exp=12345678", rsp_rdata); end
    checks++; if ({rsp_resp, rsp_timeout} !== 3'b000) begin failures++; $display("FAIL rd_resp act=%b exp=000", {rsp_resp, rsp_timeout}); end
    finish_rsp();
  endtask

  task automatic test_write_w_first();
    int hs;
    clear_slave();
    m_axi_wready = 1'b1;
    send_cmd(1'b1, 9'h140, 32'h0F0F_0F0F, 4'hC);
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin failures++; $display("FAIL wf_t1 act=%b exp=11", {m_axi_awvalid, m_axi_wvalid}); end
    tick();
    m_axi_wready = 1'b0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin failures++; $display("FAIL wf_t2 act=%b exp=10", {m_axi_awvalid, m_axi_wvalid}); end
    tick();
    m_axi_awready = 1'b1;
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100) begin
      failures++; $display("FAIL wf_t3 act=%b exp=100", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
    tick();
    m_axi_awready = 1'b0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b00) begin failures++; $display("FAIL wf_t4 act=%b exp=00", {m_axi_awvalid, m_axi_wvalid}); end
    // bvalid stays high past the handshake; only one B handshake may happen
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_axi_bready && m_axi_bvalid) hs++;
      tick();
    end
    m_axi_bvalid = 1'b0;
    checks++; if (hs !== 1) begin failures++; $display("FAIL wf_b_handshakes act=%0d exp=1", hs); end
    checks++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      failures++; $display("FAIL wf_rsp act=%0h exp=%0h", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0}); end
    finish_rsp();
  endtask

  task automatic test_rsp_hold();
    int lat;
    run_txn(1'b0, 9'h10C, 32'h0, 2'b01, 32'hCAFE_F00D, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL hold_read_latency act=%0d exp=4", lat); end
    // a pending command must not be taken while the response waits
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h1FF; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_rdata, rsp_resp, cmd_ready} !== {1'b1, 32'hCAFE_F00D, 2'b01, 1'b0}) begin
        failures++; $display("FAIL hold_stable%0d act=%0h exp=%0h", i, {rsp_valid, rsp_rdata, rsp_resp, cmd_ready}, {1'b1, 32'hCAFE_F00D, 2'b01, 1'b0}); end
      tick();
    end
    rsp_ready = 1'b1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hold_cmd_ready_same act=%0b exp=0", cmd_ready); end
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    checks++; if ({cmd_ready, rsp_valid, m_axi_awvalid} !== 3'b100) begin
      failures++; $display("FAIL hold_release act=%b exp=100", {cmd_ready, rsp_valid, m_axi_awvalid}); end
    tick();
    checks++; if ({cmd_ready, m_axi_awvalid, m_axi_arvalid} !== 3'b100) begin
      failures++; $display("FAIL hold_no_accept act=%b exp=100", {cmd_ready, m_axi_awvalid, m_axi_arvalid}); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int nrsp;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_55AA;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h108;
    nrsp = 0;
    for (int c = 0; c < 15; c++) begin
      if (cmd_valid && cmd_ready) acc.push_back(c);
      if (rsp_valid) begin
        nrsp++;
        checks++; if (rsp_rdata !== 32'h0000_55AA) begin failures++; $display("FAIL b2b_rdata act=%0h exp=55aa", rsp_rdata); end
      end
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    clear_slave();
    checks++; if (acc.size() !== 3) begin failures++; $display("FAIL b2b_accepts act=%0d exp=3", acc.size()); end
    checks++; if (nrsp !== 3) begin failures++; $display("FAIL b2b_responses act=%0d exp=3", nrsp); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] !== 5) begin failures++; $display("FAIL b2b_gap%0d act=%0d exp=5", i, acc[i] - acc[i-1]); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_slave();
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    send_cmd(1'b1, 9'h120, 32'hDEAD_BEEF, 4'h3);
    tick();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    tick();
    checks++; if (m_axi_bready !== 1'b1) begin failures++; $display("FAIL rm_in_wresp act=%0b exp=1", m_axi_bready); end
    aresetn = 1'b0;
    #1;
    checks++; if ({cmd_ready, m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, rsp_valid} !== 7'b1000000) begin
      failures++; $display("FAIL rm_async act=%b exp=1000000", {cmd_ready, m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, rsp_valid}); end
    checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== '0) begin
      failures++; $display("FAIL rm_regs act=%0h exp=0", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}); end
    m_axi_bvalid = 1'b1;
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rsp_valid, m_axi_bready, cmd_ready} !== 3'b001) begin
        failures++; $display("FAIL rm_quiet%0d act=%b exp=001", i, {rsp_valid, m_axi_bready, cmd_ready}); end
      tick();
    end
    clear_slave();
    run_txn(1'b1, 9'h124, 32'h0000_0042, 2'b00, 32'h0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL rm_next_latency act=%0d exp=4", lat); end
    checks++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin
      failures++; $display("FAIL rm_next_rsp act=%0h exp=%0h", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0}); end
    finish_rsp();
  endtask

`ifdef AXIL_IIC_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    clear_slave();
    send_cmd(1'b0, 9'h1F0, 32'h0, 4'h0);
    n = 0;
    while (m_axi_arvalid && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL to_arvalid_cycles act=%0d exp=16", n); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {1'b1, 1'b1, 2'b10, 32'h0}) begin
      failures++; $display("FAIL to_rsp act=%0h exp=%0h", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b10, 32'h0}); end
    checks++; if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin failures++; $display("FAIL to_bus_dropped act=%b exp=00", {m_axi_arvalid, m_axi_rready}); end
    finish_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_delayed_ar();
    test_write_w_first();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef AXIL_IIC_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_iic_initiator.md
# axil_iic_initiator

AXI4-Lite initiator that converts a simple single-entry command/response interface into AXI4-Lite read and write transactions. It drives the register port of the on-chip IIC controller (9-bit address, 32-bit data), so control logic can program and poll that controller without a processor. It sits between the IIC sequencing logic and the controller's AXI4-Lite slave port.

## Interface
Parameters:
- ADDR_W, 9, AXI address width
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; only meaningful with the watchdog compiled in (see Configuration)

Ports:
- clk  in  1  single clock for all logic
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  register byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI BRESP or RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  set when the transaction was ended by the watchdog
- m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master signals, widths ADDR_W/32/4/2

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WRESP, RADDR, RDATA, RSP.
- IDLE: cmd_ready=1.
  - On cmd_valid, capture all cmd_* fields into registers.
  - Go to WR if cmd_write=1, otherwise to RADDR.
- WR:
  - awvalid and wvalid both assert on entry.
  - Each valid deasserts independently on its own handshake (valid & ready).
  - When both have completed, in any order or in the same cycle, go to WRESP.
- WRESP: bready=1. On bvalid, latch bresp, set rdata=0, go to RSP.
- RADDR: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, latch rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* outputs stay stable until rsp_ready.
  - On rsp_ready, return to IDLE. cmd_ready goes high the following cycle.
- One transaction in flight at a time. No outstanding-transaction overlap.
- bready and rready are asserted only in WRESP and RDATA respectively. Stray bvalid or rvalid seen in any other state is ignored.
- All outputs are registered.
- Reset values: cmd_ready=1, all m_axi valids and readies=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, addresses, data and strobes=0, state=IDLE.
- Reset asserted mid-transaction:
  - All valids drop immediately (asynchronously).
  - The captured command is discarded and no response is produced.

## Timing
- Command accepted on cycle T. awvalid, wvalid or arvalid is high from T+1.
- Write with zero-wait slave (ready held at 1, bvalid on the cycle after the W handshake): rsp_valid at T+4.
- Read with zero-wait slave: rsp_valid at T+4.
- Back-to-back throughput: at most one command every 5 cycles.
- An address with unaligned low bits is passed through unchanged. The initiator does no alignment checking.

## Configuration
- Macro AXIL_IIC_INIT_TIMEOUT_EN.
- Defined:
  - A counter clears on every entry to WR or RADDR and increments each cycle while in WR, WRESP, RADDR or RDATA.
  - On reaching TIMEOUT_CYCLES, all m_axi valids and readies drop and the FSM goes to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - This is deliberate fault recovery that violates AXI valid-hold rules; the bus is treated as dead.
- Undefined:
  - No counter logic is built, rsp_timeout is tied to 0, and the FSM waits indefinitely.

## Test plan
- Write addr 0x100, data 0x0000_00A5, wstrb 0xF, zero-wait slave -> AW/W show 0x100/0xA5/0xF; rsp_valid at T+4 with rsp_resp=0, rsp_rdata=0.
- Read addr 0x104 with slave rdata=0x1234_5678, arready delayed 3 cycles -> arvalid held stable for 4 cycles; rsp_rdata=0x12345678, rsp_resp=0.
- Write with wready arriving 2 cycles before awready -> wvalid drops after its handshake, awvalid holds; exactly one B handshake; rsp_resp equals slave bresp=2'b10.
- rsp_ready held low 5 cycles after response -> rsp_* stable throughout; cmd_ready=0 until the cycle after rsp_ready.
- With AXIL_IIC_INIT_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles; rsp_timeout=1, rsp_resp=2'b10.
- aresetn pulsed low during WRESP -> all outputs return to reset values immediately; no rsp_valid afterwards; the next command completes normally.
